// File: rtl/tone_period_meter.sv
// Tone period meter: measures the period of a comparator square wave in
// clock cycles, averages 2^AVG_LOG2 consecutive periods and reports whether
// the average lies inside a lock window. A watchdog aborts the measurement
// when no edge is accepted for TIMEOUT clocks.
module tone_period_meter #(
    parameter int CNT_WIDTH  = 20,
    parameter int AVG_LOG2   = 3,
    parameter int MIN_PERIOD = 161,
    parameter int MAX_PERIOD = 173,
    parameter int GLITCH_MIN = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] period_out,
    output logic                 valid,
    output logic                 timeout,
    output logic                 locked
);

    localparam int ACC_W  = CNT_WIDTH + AVG_LOG2;
    localparam int SCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;

    localparam logic [SCNT_W-1:0]  SCNT_LAST   = SCNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_WIDTH:0] GLITCH_V    = (CNT_WIDTH+1)'(GLITCH_MIN);
    localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] MIN_V     = CNT_WIDTH'(MIN_PERIOD);
    localparam logic [CNT_WIDTH-1:0] MAX_V     = CNT_WIDTH'(MAX_PERIOD);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT   = '1;

    logic                 sync1_reg, sync2_reg, hist_reg;
    logic [1:0]           state_reg, state_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic [ACC_W-1:0]     acc_reg, acc_next;
    logic [SCNT_W-1:0]    scnt_reg, scnt_next;
    logic [CNT_WIDTH-1:0] period_reg, period_next;
    logic                 valid_reg, valid_next;
    logic                 timeout_reg, timeout_next;
    logic                 locked_reg, locked_next;

    logic                 rise;
    logic [CNT_WIDTH:0]   sample;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [ACC_W-1:0]     acc_sum;
    logic [CNT_WIDTH-1:0] avg_new;
    logic                 glitch;
    logic                 to_hit;

    // Two-flop synchronizer for the asynchronous input plus a history flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            hist_reg  <= 1'b0;
        end else begin
            sync1_reg <= sig_in;
            sync2_reg <= sync1_reg;
            hist_reg  <= sync2_reg;
        end
    end

    assign rise    = sync2_reg & ~hist_reg;
    // Sample is one wider than the counter so a saturated count cannot wrap to zero
    assign sample  = {1'b0, cnt_reg} + (CNT_WIDTH+1)'(1);
    assign cnt_inc = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + CNT_WIDTH'(1);
    assign acc_sum = acc_reg + ACC_W'(sample);
    assign avg_new = CNT_WIDTH'(acc_sum >> AVG_LOG2);
    assign glitch  = (sample < GLITCH_V);
    assign to_hit  = (cnt_reg == TO_LAST);

    // Next-state logic: sequencing, period counting, averaging and watchdog
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        acc_next     = acc_reg;
        scnt_next    = scnt_reg;
        period_next  = period_reg;
        valid_next   = 1'b0;
        timeout_next = timeout_reg;
        locked_next  = locked_reg;

        if (!enable) begin
            state_next  = ST_IDLE;
            cnt_next    = '0;
            acc_next    = '0;
            scnt_next   = '0;
            locked_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_ARM;
                    cnt_next   = '0;
                    acc_next   = '0;
                    scnt_next  = '0;
                end
                ST_ARM: begin
                    if (rise) begin
                        // First edge only establishes the phase reference
                        cnt_next   = '0;
                        state_next = ST_MEASURE;
                    end else if (to_hit) begin
                        timeout_next = 1'b1;
                        locked_next  = 1'b0;
                        acc_next     = '0;
                        scnt_next    = '0;
                        cnt_next     = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                ST_MEASURE: begin
                    if (rise && !glitch) begin
                        cnt_next = '0;
                        if (scnt_reg == SCNT_LAST) begin
                            period_next  = avg_new;
                            valid_next   = 1'b1;
                            locked_next  = (avg_new >= MIN_V) && (avg_new <= MAX_V);
                            timeout_next = 1'b0;
                            acc_next     = '0;
                            scnt_next    = '0;
                        end else begin
                            acc_next  = acc_sum;
                            scnt_next = scnt_reg + SCNT_W'(1);
                        end
                    end else if (to_hit && !rise) begin
                        timeout_next = 1'b1;
                        locked_next  = 1'b0;
                        acc_next     = '0;
                        scnt_next    = '0;
                        cnt_next     = '0;
                        state_next   = ST_ARM;
                    end else begin
                        // Rejected glitch edges leave the running count untouched
                        cnt_next = cnt_inc;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    acc_next   = '0;
                    scnt_next  = '0;
                end
            endcase
        end
    end

    // State and output registers; reset discards any partial average
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            scnt_reg    <= '0;
            period_reg  <= '0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            locked_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            acc_reg     <= acc_next;
            scnt_reg    <= scnt_next;
            period_reg  <= period_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
            locked_reg  <= locked_next;
        end
    end

    assign period_out = period_reg;
    assign valid      = valid_reg;
    assign timeout    = timeout_reg;
    assign locked     = locked_reg;

endmodule

// File: tb/tb_tone_period_meter.sv
// Bench for tone_period_meter: directed square-wave streams, expected
// averages queued ahead of the completing edge and checked by a monitor.
module tb_tone_period_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sig_in;
    logic [19:0] period_out;
    logic        valid;
    logic        timeout;
    logic        locked;

    typedef struct {
        logic [19:0] period;
        logic        locked;
        logic        timeout;
    } exp_t;

    exp_t exp_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;

    tone_period_meter dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sig_in     (sig_in),
        .period_out (period_out),
        .valid      (valid),
        .timeout    (timeout),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
            $display("check %-16s got %0d expected %0d ok", name, actual, expected);
        end else begin
            $display("FAIL %-16s got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Hold sig_in at a level for n clocks, changing just after the rising edge
    task automatic drive_seg(input logic val, input int n);
        repeat (n) begin
            @(posedge clk);
            #1 sig_in = val;
        end
    endtask

    task automatic drive_period(input int h, input int l);
        drive_seg(1'b1, h);
        drive_seg(1'b0, l);
    endtask

    // Return to IDLE then re-enable, so the next rise only arms
    task automatic restart();
        @(posedge clk);
        #1 enable = 1'b0;
        sig_in = 1'b0;
        repeat (5) @(posedge clk);
        #1 enable = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic expect_avg(input int p, input logic l);
        exp_t e;
        e.period  = 20'(p);
        e.locked  = l;
        e.timeout = 1'b0;
        exp_q.push_back(e);
    endtask

    // Monitor: every valid pulse must match the oldest queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (valid) begin
                checks_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_valid got period %0d locked %0d, expected no valid",
                             period_out, locked);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (period_out == e.period && locked == e.locked && timeout == e.timeout) begin
                        checks_passed++;
                        $display("valid period %0d locked %0d timeout %0d ok",
                                 period_out, locked, timeout);
                    end else begin
                        $display("FAIL avg_result got p=%0d l=%0d t=%0d expected p=%0d l=%0d t=%0d",
                                 period_out, locked, timeout, e.period, e.locked, e.timeout);
                    end
                end
            end
        end
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        sig_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_period", int'(period_out), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_locked", int'(locked), 0);
        reset  = 1'b0;
        enable = 1'b0;
        sig_in = 1'b0;

        // Constant 168 stream, 9 rises; valid exactly 3 clocks after the 9th
        restart();
        for (int k = 0; k < 8; k++) drive_period(84, 84);
        expect_avg(168, 1'b1);
        for (int i = 0; i < 168; i++) begin
            @(posedge clk);
            #1 sig_in = (i < 84);
            if (i == 2) check("valid_not_early", int'(valid), 0);
            if (i == 3) check("valid_at_rise+3", int'(valid), 1);
        end

        // Signal lost: timeout exactly 4096 clocks after the last accepted rise
        repeat (3931) @(posedge clk);
        #1 check("timeout_not_yet", int'(timeout), 0);
        @(posedge clk);
        #1;
        check("timeout_set", int'(timeout), 1);
        check("timeout_unlock", int'(locked), 0);
        check("timeout_hold_p", int'(period_out), 168);

        // Signal returns: arm, 8 samples, timeout cleared by the valid
        for (int k = 0; k < 8; k++) drive_period(84, 84);
        expect_avg(168, 1'b1);
        drive_period(84, 84);
        check("timeout_cleared", int'(timeout), 0);

        // Alternating 160/176 averages to 168
        restart();
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) drive_period(80, 80);
            else            drive_period(88, 88);
        end
        expect_avg(168, 1'b1);
        drive_period(84, 84);

        // Constant 200 is outside the lock window
        restart();
        for (int k = 0; k < 8; k++) drive_period(100, 100);
        expect_avg(200, 1'b0);
        drive_period(100, 100);

        // Short pulse right after a rise yields a 7-clock sample, which is rejected
        restart();
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                drive_seg(1'b1, 3);
                drive_seg(1'b0, 4);
                drive_seg(1'b1, 77);
                drive_seg(1'b0, 84);
            end else begin
                drive_period(84, 84);
            end
        end
        expect_avg(168, 1'b1);
        drive_period(84, 84);

        // Reset after 5 samples clears everything and needs 9 fresh rises
        restart();
        for (int k = 0; k < 6; k++) drive_period(84, 84);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_period", int'(period_out), 0);
        check("mid_rst_valid", int'(valid), 0);
        check("mid_rst_timeout", int'(timeout), 0);
        check("mid_rst_locked", int'(locked), 0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        for (int k = 0; k < 8; k++) drive_period(85, 85);
        expect_avg(170, 1'b1);
        drive_period(85, 85);

        // Enable dropped mid-average: unlock, hold period, then a fresh arm
        restart();
        for (int k = 0; k < 5; k++) drive_period(84, 84);
        #1 enable = 1'b0;
        @(posedge clk);
        #1;
        check("dis_locked", int'(locked), 0);
        check("dis_period_hold", int'(period_out), 170);
        check("dis_timeout", int'(timeout), 0);
        repeat (5) @(posedge clk);
        #1 enable = 1'b1;
        repeat (5) @(posedge clk);
        for (int k = 0; k < 8; k++) drive_period(84, 84);
        expect_avg(168, 1'b1);
        drive_period(84, 84);

        repeat (20) @(posedge clk);
        #1 check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/tone_period_meter.md
TONE_PERIOD_METER -- requirements
Module: tone_period_meter

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 20; width of the period counter, accumulator base and period_out.
REQ-002 SHALL have parameter AVG_LOG2, default 3; averages over 2^AVG_LOG2 periods.
REQ-003 SHALL have parameter MIN_PERIOD, default 161; lower lock bound, in clocks (310 kHz at 50 MHz).
REQ-004 SHALL have parameter MAX_PERIOD, default 173; upper lock bound, in clocks (290 kHz at 50 MHz).
REQ-005 SHALL have parameter GLITCH_MIN, default 16; edges closer than this many clocks are rejected.
REQ-006 SHALL have parameter TIMEOUT, default 4096; clocks without an accepted edge before abort.
REQ-007 SHALL have port clk, input, 1 bit; the single clock of the block.
REQ-008 SHALL have port reset, input, 1 bit; synchronous, active-high.
REQ-009 SHALL have port enable, input, 1 bit; measurement runs while high.
REQ-010 SHALL have port sig_in, input, 1 bit; asynchronous square wave from the comparator.
REQ-011 SHALL have port period_out, output, CNT_WIDTH bits; averaged period in clocks.
REQ-012 SHALL have port valid, output, 1 bit; one-cycle pulse when period_out updates.
REQ-013 SHALL have port timeout, output, 1 bit; sticky flag for no-signal abort.
REQ-014 SHALL have port locked, output, 1 bit; last average lies within [MIN_PERIOD, MAX_PERIOD].

Function
REQ-015 SHALL pass sig_in through a two-flop synchronizer plus one history flop; rise = sync2 & ~hist.
REQ-016 SHALL implement states IDLE, ARM and MEASURE.
REQ-017 SHALL move IDLE->ARM when enable=1; any state SHALL go to IDLE whenever enable=0.
REQ-018 SHALL ignore rises in IDLE; in IDLE, cnt, acc and sample count SHALL be cleared.
REQ-019 SHALL, on the first rise in ARM, set cnt<=0 and move to MEASURE without producing a sample.
REQ-020 SHALL increment cnt every cycle in ARM/MEASURE except a cycle with an accepted rise, which sets cnt<=0; cnt SHALL never wrap.
REQ-021 SHALL, on a rise in MEASURE, form sample = cnt+1, which equals the clock count between successive rises.
REQ-022 SHALL ignore a rise with sample < GLITCH_MIN; cnt SHALL keep counting and no sample SHALL be recorded.
REQ-023 SHALL accumulate each accepted sample into acc, of width CNT_WIDTH+AVG_LOG2, and count it.
REQ-024 SHALL, on the 2^AVG_LOG2-th sample, register period_out = (acc+sample)>>AVG_LOG2 (truncating) and pulse valid for exactly 1 cycle, in the cycle after that rise.
REQ-025 SHALL clear acc and the sample count at the same point and stay in MEASURE (continuous back-to-back averages).
REQ-026 SHALL update locked together with valid: 1 if MIN_PERIOD <= period_out <= MAX_PERIOD, else 0.
REQ-027 SHALL, when cnt == TIMEOUT-1 in ARM/MEASURE with no rise that cycle, set timeout=1, locked=0, clear acc and sample count, set cnt<=0 and enter ARM.
REQ-028 SHALL give precedence to a rise over the timeout in the same cycle; sample = TIMEOUT and no timeout is raised.
REQ-029 SHALL hold timeout until the next valid pulse or reset.
REQ-030 SHALL hold period_out through timeout and IDLE; enable=0 SHALL force locked=0 and SHALL leave timeout unchanged.
REQ-031 SHALL have a synchronizer latency of 3 clocks from a sig_in transition to rise detection.

Reset
REQ-032 SHALL, on reset=1 at a clk edge, set state=IDLE and clear cnt, acc, sample count, synchronizer and history flops, period_out=0, valid=0, timeout=0 and locked=0; reset SHALL override all other inputs.
REQ-033 SHALL discard any partial average when reset is applied mid-measurement.

Verification
REQ-034 SHALL cover: enable=1, period-168 square wave (84 high/84 low), 9 rises -> single valid after the 9th rise+3 cycles, period_out=168, locked=1.
REQ-035 SHALL cover: period alternating 160/176 for 8 samples -> period_out=168, locked=1; a constant 200-clock period -> period_out=200, locked=0.
REQ-036 SHALL cover: sig_in held low after lock -> timeout=1 and locked=0 exactly 4096 cycles after the last accepted rise, period_out unchanged; toggling resumes -> timeout clears on the next valid.
REQ-037 SHALL cover: a 3-clock high glitch inserted mid-period in a 168 stream -> glitch rejected, period_out=168.
REQ-038 SHALL cover: reset after 5 samples -> all outputs 0 the next cycle, and the first valid after resume requires 9 fresh rises.
REQ-039 SHALL cover: enable dropped mid-average -> no valid, locked=0, period_out held; re-enable -> ARM, first rise produces no sample.
